// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 from a 100 MHz clock) and fetch FSM encoding.
package vga_pkg;
    localparam int   VGA_CLK_DIV    = 4;
    localparam int   VGA_H_ACTIVE   = 640;
    localparam int   VGA_H_FP       = 16;
    localparam int   VGA_H_SYNC     = 96;
    localparam int   VGA_H_BP       = 48;
    localparam int   VGA_V_ACTIVE   = 480;
    localparam int   VGA_V_FP       = 10;
    localparam int   VGA_V_SYNC     = 2;
    localparam int   VGA_V_BP       = 33;
    localparam logic VGA_SYNC_POL   = 1'b0;
    localparam int   VGA_FETCH_LEAD = 8;
    localparam int   CW             = 10;

    typedef enum logic [1:0] {
        F_IDLE     = 2'd0,
        F_REQ      = 2'd1,
        F_WAIT_END = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus registered sync/active window flags.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = 800,
    parameter int   ACTIVE     = 640,
    parameter int   SYNC_START = 656,
    parameter int   SYNC_LEN   = 96,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          last,
    output logic          sync,
    output logic          act
);
    always_comb begin
        last    = (cnt == CW'(TOTAL - 1));
        cnt_nxt = cnt;
        if (clr || (adv && last))
            cnt_nxt = '0;
        else if (adv)
            cnt_nxt = cnt + CW'(1);
    end

    // Flags are derived from the next count so they line up with cnt in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= ~SYNC_POL;
            act  <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            sync <= ~SYNC_POL;
            act  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            sync <= (cnt_nxt >= CW'(SYNC_START) && cnt_nxt < CW'(SYNC_START + SYNC_LEN))
                    ? SYNC_POL : ~SYNC_POL;
            act  <= (cnt_nxt < CW'(ACTIVE));
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, H/V counters, sync/active and the PPU line-fetch handshake.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV    = VGA_CLK_DIV,
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter logic SYNC_POL   = VGA_SYNC_POL,
    parameter int   FETCH_LEAD = VGA_FETCH_LEAD
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          fetch_req,
    output logic [CW-1:0] fetch_line,
    input  logic          fetch_ack,
    output logic          underrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    logic [DW-1:0] div, div_nxt;
    logic          div_last, adv_h, pce_nxt, h_wrap;
    logic [CW-1:0] x_nxt, y_nxt, next_line;
    logic          h_last, v_last, h_act, v_act;
    fetch_state_t  fstate;

    assign div_last = (div == DW'(CLK_DIV - 1));
    assign adv_h    = enable && div_last;
    assign div_nxt  = (!enable || div_last) ? '0 : div + DW'(1);
    assign pce_nxt  = enable && (div_nxt == DW'(CLK_DIV - 1));
    assign h_wrap   = adv_h && h_last;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_LEN(H_SYNC), .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst_n(reset_n), .clr(!enable), .adv(adv_h),
        .cnt(x), .cnt_nxt(x_nxt), .last(h_last), .sync(hsync), .act(h_act)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_LEN(V_SYNC), .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst_n(reset_n), .clr(!enable), .adv(h_wrap),
        .cnt(y), .cnt_nxt(y_nxt), .last(v_last), .sync(vsync), .act(v_act)
    );

    assign active = h_act && v_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_ce      <= pce_nxt;
            line_start  <= pce_nxt && (x_nxt == '0);
            frame_start <= pce_nxt && (x_nxt == '0) && (y_nxt == '0);
        end
    end

    // Line V_TOTAL-1 wraps to 0, so line 0 is prefetched during the last blanking line.
    assign next_line = v_last ? '0 : y + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fstate     <= F_IDLE;
            fetch_req  <= 1'b0;
            fetch_line <= '0;
            underrun   <= 1'b0;
        end else if (!enable) begin
            fstate     <= F_IDLE;
            fetch_req  <= 1'b0;
            fetch_line <= '0;
        end else begin
            case (fstate)
                F_IDLE: begin
                    if (adv_h && x_nxt == CW'(H_ACTIVE) && next_line < CW'(V_ACTIVE)) begin
                        fetch_req  <= 1'b1;
                        fetch_line <= next_line;
                        fstate     <= F_REQ;
                    end
                end
                F_REQ: begin
                    // An ack landing on the deadline clock still counts as in time.
                    if (fetch_ack) begin
                        fetch_req <= 1'b0;
                        fstate    <= F_WAIT_END;
                    end else if (adv_h && x_nxt == CW'(H_TOTAL - FETCH_LEAD)) begin
                        underrun  <= 1'b1;
                        fetch_req <= 1'b0;
                        fstate    <= F_WAIT_END;
                    end
                end
                F_WAIT_END: begin
                    if (h_wrap)
                        fstate <= F_IDLE;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed checks on the 640x480 set, model-checked random run on a tiny raster.
module tb_vga_timing_gen;
    localparam int SD = 2;
    localparam int SHA = 8, SHF = 1, SHS = 2, SHB = 1, SHT = SHA + SHF + SHS + SHB;
    localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1, SVT = SVA + SVF + SVS + SVB;
    localparam int SFL = 2;
    localparam logic SPOL = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst_d = 1'b0, en_d = 1'b0, ack_d = 1'b0;
    logic       pix_ce_d, hsync_d, vsync_d, active_d, line_start_d, frame_start_d, fetch_req_d, underrun_d;
    logic [9:0] x_d, y_d, fetch_line_d;

    logic       rst_s = 1'b0, en_s = 1'b0, ack_s = 1'b0;
    logic       pix_ce_s, hsync_s, vsync_s, active_s, line_start_s, frame_start_s, fetch_req_s, underrun_s;
    logic [9:0] x_s, y_s, fetch_line_s;

    vga_timing_gen dut_d (
        .clk(clk), .reset_n(rst_d), .enable(en_d), .pix_ce(pix_ce_d), .hsync(hsync_d),
        .vsync(vsync_d), .active(active_d), .x(x_d), .y(y_d), .line_start(line_start_d),
        .frame_start(frame_start_d), .fetch_req(fetch_req_d), .fetch_line(fetch_line_d),
        .fetch_ack(ack_d), .underrun(underrun_d)
    );

    vga_timing_gen #(
        .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(SPOL), .FETCH_LEAD(SFL)
    ) dut_s (
        .clk(clk), .reset_n(rst_s), .enable(en_s), .pix_ce(pix_ce_s), .hsync(hsync_s),
        .vsync(vsync_s), .active(active_s), .x(x_s), .y(y_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .fetch_req(fetch_req_s), .fetch_line(fetch_line_s),
        .fetch_ack(ack_s), .underrun(underrun_s)
    );

    // Reference model for the small raster: everything follows from the count of enabled clocks.
    int   cs;
    logic seen, under_m;

    function automatic int mx(int c); return (c / SD) % SHT; endfunction
    function automatic int my(int c); return (c / (SD * SHT)) % SVT; endfunction
    function automatic logic mreq(int c, logic s);
        return c != 0 && ((my(c) + 1) % SVT) < SVA && mx(c) >= SHA && mx(c) < SHT - SFL && !s;
    endfunction
    function automatic logic [25:0] mras(int c);
        int xx, yy;
        logic pce, hs, vs, ac, ls, fs;
        if (c == 0) return {1'b0, ~SPOL, ~SPOL, 3'b000, 20'd0};
        xx  = mx(c);
        yy  = my(c);
        pce = (c % SD) == SD - 1;
        hs  = (xx >= SHA + SHF && xx < SHA + SHF + SHS) ? SPOL : ~SPOL;
        vs  = (yy >= SVA + SVF && yy < SVA + SVF + SVS) ? SPOL : ~SPOL;
        ac  = xx < SHA && yy < SVA;
        ls  = pce && xx == 0;
        fs  = ls && yy == 0;
        return {pce, hs, vs, ac, ls, fs, 10'(xx), 10'(yy)};
    endfunction

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            cs <= 0; seen <= 1'b0; under_m <= 1'b0;
        end else if (!en_s) begin
            cs <= 0; seen <= 1'b0;
        end else begin
            cs <= cs + 1;
            if (mx(cs + 1) < SHA) seen <= 1'b0;
            else if (mreq(cs, seen) && ack_s) seen <= 1'b1;
            if (mreq(cs, seen) && !ack_s && mx(cs + 1) == SHT - SFL) under_m <= 1'b1;
        end
    end

    task automatic test_reset();
        int k = 0;
        rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
        repeat (9) @(negedge clk);
        total++; if (hsync_d !== 1'b1 || vsync_d !== 1'b1) begin bad++; $display("FAIL reset_sync got=%b%b exp=11", hsync_d, vsync_d); end
        total++; if (x_d !== 10'd0 || y_d !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", x_d, y_d); end
        total++; if ({fetch_req_d, underrun_d, pix_ce_d, active_d, fetch_line_d} !== 14'd0) begin bad++; $display("FAIL reset_misc got=%b%b%b%b line=%0d exp=0", fetch_req_d, underrun_d, pix_ce_d, active_d, fetch_line_d); end
        total++; if (hsync_s !== ~SPOL || vsync_s !== ~SPOL) begin bad++; $display("FAIL reset_pol got=%b%b exp=%b%b", hsync_s, vsync_s, ~SPOL, ~SPOL); end
        rst_d = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pix_ce_d) begin k = i; break; end
        end
        total++; if (k !== 3) begin bad++; $display("FAIL first_pix_ce got=%0d exp=3", k); end
        total++; if (frame_start_d !== 1'b1 || line_start_d !== 1'b1 || x_d !== 10'd0) begin bad++; $display("FAIL first_frame_start got=%b%b x=%0d exp=11 x=0", frame_start_d, line_start_d, x_d); end
    endtask

    task automatic wait_req_d(input string nm, input int bound);
        int n = 0;
        while (!fetch_req_d && n < bound) begin @(negedge clk); n++; end
        total++; if (fetch_req_d !== 1'b1) begin bad++; $display("FAIL %s_timeout got=%b exp=1", nm, fetch_req_d); end
    endtask

    task automatic test_fetch_ack();
        wait_req_d("fetch_wait", 3000);
        total++; if (fetch_line_d !== 10'd1 || x_d !== 10'd640 || y_d !== 10'd0) begin bad++; $display("FAIL fetch_rise got line=%0d x=%0d y=%0d exp 1,640,0", fetch_line_d, x_d, y_d); end
        repeat (2) @(negedge clk);
        total++; if (fetch_req_d !== 1'b1) begin bad++; $display("FAIL fetch_hold got=%b exp=1", fetch_req_d); end
        ack_d = 1'b1;
        @(negedge clk);
        ack_d = 1'b0;
        total++; if (fetch_req_d !== 1'b0 || underrun_d !== 1'b0) begin bad++; $display("FAIL fetch_drop got req=%b und=%b exp 0,0", fetch_req_d, underrun_d); end
    endtask

    task automatic test_hsync();
        int t = 0, f1 = -1, r1 = -1, f2 = -1;
        logic ph = hsync_d;
        while (f2 < 0 && t < 8000) begin
            @(negedge clk); t++;
            if (ph && !hsync_d) begin
                if (f1 < 0) begin
                    f1 = t;
                    total++; if (x_d !== 10'd656) begin bad++; $display("FAIL hsync_start got x=%0d exp=656", x_d); end
                end else f2 = t;
            end
            if (!ph && hsync_d && f1 >= 0 && r1 < 0) r1 = t;
            ph = hsync_d;
        end
        total++; if (r1 - f1 !== 384) begin bad++; $display("FAIL hsync_width got=%0d exp=384", r1 - f1); end
        total++; if (f2 - f1 !== 3200) begin bad++; $display("FAIL hsync_period got=%0d exp=3200", f2 - f1); end
        total++; if (vsync_d !== 1'b1) begin bad++; $display("FAIL vsync_idle got=%b exp=1", vsync_d); end
    endtask

    task automatic test_underrun();
        int n = 0;
        total++; if (underrun_d !== 1'b0 || fetch_req_d !== 1'b1 || fetch_line_d !== 10'd2) begin bad++; $display("FAIL under_pre got und=%b req=%b line=%0d exp 0,1,2", underrun_d, fetch_req_d, fetch_line_d); end
        while (fetch_req_d && n < 600) begin @(negedge clk); n++; end
        total++; if (fetch_req_d !== 1'b0 || x_d !== 10'd792 || y_d !== 10'd1) begin bad++; $display("FAIL under_drop got req=%b x=%0d y=%0d exp 0,792,1", fetch_req_d, x_d, y_d); end
        total++; if (underrun_d !== 1'b1) begin bad++; $display("FAIL under_flag got=%b exp=1", underrun_d); end
    endtask

    task automatic test_enable();
        int k = 0;
        wait_req_d("enable_wait", 3000);
        total++; if (underrun_d !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b exp=1", underrun_d); end
        en_d = 1'b0;
        @(negedge clk);
        total++; if ({x_d, y_d} !== 20'd0 || fetch_req_d !== 1'b0 || pix_ce_d !== 1'b0 || hsync_d !== 1'b1) begin bad++; $display("FAIL enable_off got x=%0d y=%0d req=%b ce=%b hs=%b", x_d, y_d, fetch_req_d, pix_ce_d, hsync_d); end
        total++; if (underrun_d !== 1'b1) begin bad++; $display("FAIL enable_keeps_under got=%b exp=1", underrun_d); end
        en_d = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pix_ce_d) begin k = i; break; end
        end
        total++; if (k !== 3 || frame_start_d !== 1'b1) begin bad++; $display("FAIL enable_restart got k=%0d fs=%b exp 3,1", k, frame_start_d); end
    endtask

    task automatic test_reset_pulse();
        wait_req_d("rstpulse_wait", 3000);
        #2 rst_d = 1'b0;
        #1;
        total++; if ({x_d, y_d} !== 20'd0 || fetch_req_d !== 1'b0 || underrun_d !== 1'b0 || hsync_d !== 1'b1) begin bad++; $display("FAIL rst_pulse got x=%0d y=%0d req=%b und=%b hs=%b", x_d, y_d, fetch_req_d, underrun_d, hsync_d); end
        @(negedge clk);
        rst_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({fetch_req_d, line_start_d, frame_start_d, pix_ce_d} !== 4'd0) begin bad++; $display("FAIL rst_no_pulse got=%b exp=0000", {fetch_req_d, line_start_d, frame_start_d, pix_ce_d}); end
        end
    endtask

    task automatic test_small_frame();
        int f1 = -1, f2 = -1;
        logic [9:0] px, py;
        logic pr;
        ack_s = 1'b1;
        rst_s = 1'b1;
        px = x_s; py = y_s; pr = fetch_req_s;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            total++; if ({pix_ce_s, hsync_s, vsync_s, active_s, line_start_s, frame_start_s, x_s, y_s} !== mras(cs)) begin bad++; $display("FAIL small_raster c=%0d got=%h exp=%h", cs, {pix_ce_s, hsync_s, vsync_s, active_s, line_start_s, frame_start_s, x_s, y_s}, mras(cs)); end
            if (px == 10'(SHT - 1) && x_s != px) begin total++; if (x_s !== 10'd0) begin bad++; $display("FAIL x_wrap got=%0d exp=0", x_s); end end
            if (py == 10'(SVT - 1) && y_s != py) begin total++; if (y_s !== 10'd0) begin bad++; $display("FAIL y_wrap got=%0d exp=0", y_s); end end
            if (!pr && fetch_req_s && y_s == 10'(SVT - 1)) begin total++; if (fetch_line_s !== 10'd0) begin bad++; $display("FAIL last_line_fetch got=%0d exp=0", fetch_line_s); end end
            if (frame_start_s) begin if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i; end
            px = x_s; py = y_s; pr = fetch_req_s;
        end
        total++; if (f2 - f1 !== 168) begin bad++; $display("FAIL frame_period got=%0d exp=168", f2 - f1); end
        total++; if (underrun_s !== 1'b0) begin bad++; $display("FAIL small_no_under got=%b exp=0", underrun_s); end
    endtask

    task automatic test_small_underrun();
        ack_s = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 200 || i == 400) begin
                total++; if (underrun_s !== 1'b1) begin bad++; $display("FAIL small_under i=%0d got=%b exp=1", i, underrun_s); end
            end
        end
    endtask

    task automatic test_random_small(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++; if ({pix_ce_s, hsync_s, vsync_s, active_s, line_start_s, frame_start_s, x_s, y_s} !== mras(cs)) begin bad++; $display("FAIL rand_raster c=%0d got=%h exp=%h", cs, {pix_ce_s, hsync_s, vsync_s, active_s, line_start_s, frame_start_s, x_s, y_s}, mras(cs)); end
            total++; if (fetch_req_s !== mreq(cs, seen) || (fetch_req_s && fetch_line_s !== 10'((my(cs) + 1) % SVT))) begin bad++; $display("FAIL rand_fetch c=%0d got req=%b line=%0d exp req=%b line=%0d", cs, fetch_req_s, fetch_line_s, mreq(cs, seen), (my(cs) + 1) % SVT); end
            total++; if (underrun_s !== under_m) begin bad++; $display("FAIL rand_underrun c=%0d got=%b exp=%b", cs, underrun_s, under_m); end
            ack_s = ($urandom_range(0, 3) == 0);
            en_s  = ($urandom_range(0, 199) != 0);
            rst_s = ($urandom_range(0, 255) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_ack();
        test_hsync();
        test_underrun();
        test_enable();
        test_reset_pulse();
        test_small_frame();
        test_small_underrun();
        test_random_small(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
